// File: rtl/pattern_buffer_reader.sv
// Pattern buffer reader: DEPTH x 16 word store filled by a pattern writer, then
// scanned out over a valid/ready port while counting words that break the marker pattern.
//
// state   | meaning
// IDLE    | waiting for start; mismatch_count holds the last scan's result
// FETCH   | one cycle: latch storage[pointer] and pointer onto the output port
// PRESENT | out_valid high, waiting for out_ready; compare on handshake
// DONE    | one-cycle done pulse, busy still high
module pattern_buffer_reader #(
  parameter int DEPTH        = 64,
  parameter int CHECK_PERIOD = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in_data,
  input  logic [15:0] in_address,
  input  logic        start,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [15:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] mismatch_count,
  output logic        wr_overflow
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   ptr;
  logic            handshake;
  logic            last_word;
  logic            wr_in_range;
  logic [15:0]     expected_word;

  assign handshake     = (state == S_PRESENT) && out_ready;
  assign last_word     = (ptr == PW'(DEPTH - 1));
  assign wr_in_range   = (in_address < 16'(DEPTH));
  // Marker check uses the full zero-extended address, not the pointer width.
  assign expected_word = ((out_addr % 16'(CHECK_PERIOD)) == 16'd0) ? 16'hFFFF : 16'h0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_PRESENT;
      S_PRESENT: if (out_ready) state_nxt = last_word ? S_DONE : S_FETCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == S_PRESENT);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
  end

  // Storage accepts writes in every state; a same-cycle FETCH sees the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
      wr_overflow <= 1'b0;
    end else if (load) begin
      if (wr_in_range) mem[in_address[PW-1:0]] <= in_data;
      else             wr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      out_data       <= 16'h0000;
      out_addr       <= 16'h0000;
      mismatch_count <= 16'h0000;
    end else begin
      if (state == S_IDLE && start) begin
        ptr            <= '0;
        mismatch_count <= 16'h0000;
      end
      if (state == S_FETCH) begin
        out_data <= mem[ptr];
        out_addr <= 16'(ptr);
      end
      if (handshake) begin
        if (out_data != expected_word && mismatch_count != 16'hFFFF)
          mismatch_count <= mismatch_count + 16'd1;
        if (!last_word) ptr <= ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pattern_buffer_reader.sv
// Scoreboard bench for pattern_buffer_reader: a word-array model predicts every
// scanned word and the mismatch total; a forked monitor checks each handshake.
module tb_pattern_buffer_reader;

  localparam int DEPTH        = 64;
  localparam int CHECK_PERIOD = 50;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] in_data;
  logic [15:0] in_address;
  logic        start;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [15:0] out_addr;
  logic        busy;
  logic        done;
  logic [15:0] mismatch_count;
  logic        wr_overflow;

  pattern_buffer_reader #(.DEPTH(DEPTH), .CHECK_PERIOD(CHECK_PERIOD)) dut (
    .clk(clk), .reset(reset), .load(load), .in_data(in_data), .in_address(in_address),
    .start(start), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done), .mismatch_count(mismatch_count),
    .wr_overflow(wr_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] ref_mem [DEPTH];
  logic        ref_ovf;
  logic [31:0] sb [$];
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pattern(input int a);
    return (a % CHECK_PERIOD == 0) ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic clear_model();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 16'h0000;
    ref_ovf = 1'b0;
    sb.delete();
  endtask

  // Entered and left at posedge+1.
  task automatic do_write(input int addr, input logic [15:0] data);
    load = 1'b1; in_address = 16'(addr); in_data = data;
    @(posedge clk); #1;
    load = 1'b0;
    if (addr < DEPTH) ref_mem[addr] = data;
    else              ref_ovf = 1'b1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic int push_scan();
    int mis;
    mis = 0;
    for (int a = 0; a < DEPTH; a++) begin
      sb.push_back({16'(a), ref_mem[a]});
      if (ref_mem[a] != pattern(a)) mis++;
    end
    return mis;
  endfunction

  // ready_mode 0: out_ready held high; 1: random out_ready plus a stray start mid-scan.
  // inj_addr > 0: write inj_data to inj_addr during the FETCH that reads it.
  task automatic run_scan(input int ready_mode, input int inj_addr, input logic [15:0] inj_data);
    int   exp_mis;
    int   cyc;
    int   inj_stage;
    logic got_done;
    exp_mis   = push_scan();
    start     = 1'b1;
    cyc       = 0;
    inj_stage = 0;
    got_done  = 1'b0;
    while (!got_done && cyc < 40 * DEPTH) begin
      @(posedge clk); #1;
      cyc++;
      start     = (ready_mode == 1 && cyc == 10);
      out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      load      = 1'b0;
      if (inj_stage == 1) begin
        load = 1'b1; in_address = 16'(inj_addr); in_data = inj_data;
        inj_stage = 2;
      end
      @(negedge clk);
      if (cyc == 1) chk("busy_after_start", 32'(busy), 1);
      if (inj_stage == 0 && inj_addr > 0 && out_valid && out_ready &&
          out_addr == 16'(inj_addr - 1)) inj_stage = 1;
      got_done = done;
    end
    chk("done_seen", 32'(got_done), 1);
    if (ready_mode == 0) chk("scan_cycles", cyc, 2 * DEPTH + 1);
    chk("mismatch_count", 32'(mismatch_count), exp_mis);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    @(posedge clk); #1;
    start = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_after_done", 32'(busy), 0);
    chk("mismatch_hold", 32'(mismatch_count), exp_mis);
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    logic        pv, pr;
    logic [15:0] pd, pa;
    logic [31:0] e;
    pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
    forever begin
      @(negedge clk);
      if (reset) pv = 1'b0;
      else begin
        if (pv && !pr) begin
          chk("valid_held", 32'(out_valid), 1);
          chk("data_stable", 32'(out_data), 32'(pd));
          chk("addr_stable", 32'(out_addr), 32'(pa));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word actual=%h required=none", out_addr);
          end else begin
            e = sb.pop_front();
            chk("word_addr", 32'(out_addr), 32'(e[31:16]));
            chk("word_data", 32'(out_data), 32'(e[15:0]));
          end
        end
        pv = out_valid; pr = out_ready; pd = out_data; pa = out_addr;
      end
    end
  endtask

  initial begin
    int   cnt;
    logic found;
    total = 0; bad = 0;
    reset = 1'b1; load = 1'b0; start = 1'b0; out_ready = 1'b0;
    in_data = '0; in_address = '0;
    clear_model();
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mismatch", 32'(mismatch_count), 0);
    chk("rst_overflow", 32'(wr_overflow), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Empty store: markers at 0 and 50 miss.
    run_scan(0, -1, 16'h0);
    chk("overflow_none", 32'(wr_overflow), 0);

    // Markers in place: clean scan.
    do_write(0, 16'hFFFF);
    do_write(50, 16'hFFFF);
    run_scan(0, -1, 16'h0);

    // Out-of-range write discarded and flagged.
    apply_reset();
    do_write(5, 16'h1234);
    do_write(DEPTH, 16'hBEEF);
    chk("overflow_set", 32'(wr_overflow), 32'(ref_ovf));
    run_scan(0, -1, 16'h0);
    chk("overflow_sticky", 32'(wr_overflow), 1);

    // Random contents, random back-pressure, stray start.
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 24; w++) begin
        int          sel;
        logic [15:0] d;
        sel = int'($urandom_range(0, 2));
        d   = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom());
        do_write(int'($urandom_range(0, DEPTH + 7)), d);
      end
      run_scan(1, -1, 16'h0);
      chk("overflow_model", 32'(wr_overflow), 32'(ref_ovf));
    end

    // Write colliding with the FETCH of the same address returns the old word.
    apply_reset();
    run_scan(0, 10, 16'hAAAA);
    ref_mem[10] = 16'hAAAA;
    run_scan(0, -1, 16'h0);

    // Reset mid-scan aborts without done; load/start ignored while in reset.
    do_write(20, 16'h1111);
    cnt = push_scan();
    start = 1'b1;
    cnt = 0;
    found = 1'b0;
    while (!found && cnt < 4 * DEPTH) begin
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      cnt++;
      found = out_valid && (out_addr == 16'd20);
    end
    chk("reached_word20", 32'(found), 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_out_data", 32'(out_data), 0);
    chk("abort_out_addr", 32'(out_addr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_mismatch", 32'(mismatch_count), 0);
    clear_model();
    load = 1'b1; in_address = 16'd3; in_data = 16'h5555; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done), 0);
      chk("no_busy_in_reset", 32'(busy), 0);
    end
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 32'(busy), 0);
    chk("overflow_after_reset", 32'(wr_overflow), 0);
    @(posedge clk); #1;
    run_scan(0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
